// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared FSM state type and address-width helper for router_1xn
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PAYLOAD,
    ST_PARITY,
    ST_CHECK,
    ST_DROP
  } state_t;

  function automatic int calc_addr_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-channel output FIFO with registered read data and flush
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW:0]       r_wp;
  logic [PW:0]       r_rp;
  logic [DATA_W-1:0] r_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;

  // Extra pointer bit tells a full ring from an empty one.
  assign w_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_empty = (r_wp == r_rp);
  assign w_wr    = we && !w_full && !flush;
  assign w_rd    = re && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_dout <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) begin
        r_dout <= r_mem[r_rp[PW-1:0]];
        r_rp   <= r_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wp[PW-1:0]] <= din;
  end

  assign dout  = r_dout;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/router_1xn.sv
// rtl/router_1xn.sv - 1-to-NUM_CH packet router; ROUTER_SOFTRST_EN adds idle-channel flush
module router_1xn
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  input  logic [NUM_CH-1:0]        read_enable,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     error,
  output logic                     drop
);

  localparam int ADDR_W = calc_addr_w(NUM_CH);
  localparam int LW     = DATA_W - ADDR_W;
  localparam int NPAD   = 1 << ADDR_W;

  if (NUM_CH < 2 || NUM_CH > 8 || DATA_W < ADDR_W + 2 || DEPTH < 4 ||
      (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("router_1xn: illegal parameter set");
  end

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_dest;
  logic [LW-1:0]     r_len;
  logic [DATA_W-1:0] r_parity;
  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_rx_par;
  logic              r_error;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_flush;
  logic [NPAD-1:0]   w_full_pad;
  logic [NPAD-1:0]   w_flush_pad;
  logic [ADDR_W-1:0] w_hdr_dest;
  logic [LW-1:0]     w_hdr_len;
  logic              w_hdr_ok;
  logic              w_busy;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_wsel;
  logic [DATA_W-1:0] w_wdata;
  logic              w_drop;

  assign w_hdr_dest = data_in[ADDR_W-1:0];
  assign w_hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign w_hdr_ok   = 32'(w_hdr_dest) < NUM_CH;
  assign w_accept   = pkt_valid && !w_busy;

  // Non-existent channels read as full/never-flushed so indexing by dest is always safe.
  always_comb begin
    w_full_pad  = '1;
    w_flush_pad = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_full_pad[i]  = w_full[i];
      w_flush_pad[i] = w_flush[i];
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_we    = 1'b0;
    w_wsel  = r_dest;
    w_wdata = data_in;
    w_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wsel = w_hdr_dest;
        if (pkt_valid) begin
          if (!w_hdr_ok)                   w_next = ST_DROP;
          else if (w_full_pad[w_hdr_dest]) w_next = ST_WAIT;
          else begin
            w_we   = 1'b1;
            w_next = (w_hdr_len == '0) ? ST_PARITY : ST_PAYLOAD;
          end
        end
      end
      ST_WAIT: begin
        w_busy  = 1'b1;
        w_wdata = r_hdr;
        if (!w_full_pad[r_dest]) begin
          w_we   = 1'b1;
          w_next = (r_len == '0) ? ST_PARITY : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_busy = w_full_pad[r_dest];
        if (pkt_valid && !w_busy) begin
          w_we = 1'b1;
          if (r_len == LW'(1)) w_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        w_busy = w_full_pad[r_dest];
        if (pkt_valid && !w_busy) begin
          w_we   = 1'b1;
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_busy = 1'b1;
        w_next = ST_IDLE;
      end
      ST_DROP: begin
        if (pkt_valid && r_len == '0) begin
          w_drop = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // A flushed destination abandons the packet silently.
    if ((r_state == ST_WAIT || r_state == ST_PAYLOAD || r_state == ST_PARITY) &&
        w_flush_pad[r_dest]) begin
      w_we   = 1'b0;
      w_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dest   <= '0;
      r_len    <= '0;
      r_parity <= '0;
      r_hdr    <= '0;
      r_rx_par <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (pkt_valid) begin
          r_dest   <= w_hdr_dest;
          r_len    <= w_hdr_len;
          r_parity <= data_in;
          r_hdr    <= data_in;
        end
        ST_PAYLOAD: if (w_accept) begin
          r_parity <= r_parity ^ data_in;
          r_len    <= r_len - 1'b1;
        end
        ST_PARITY: if (w_accept) r_rx_par <= data_in;
        ST_CHECK:  r_error <= (r_rx_par != r_parity);
        ST_DROP:   if (pkt_valid && r_len != '0) r_len <= r_len - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ROUTER_SOFTRST_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_idle_cnt [NUM_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset || w_flush[i])                 r_idle_cnt[i] <= '0;
      else if (w_empty[i] || read_enable[i])   r_idle_cnt[i] <= '0;
      else                                     r_idle_cnt[i] <= r_idle_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_flush[i] = (r_idle_cnt[i] == CW'(TIMEOUT));
  end
`else
  assign w_flush = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .flush(w_flush[g]),
      .we   (w_we && (w_wsel == ADDR_W'(g))),
      .re   (read_enable[g]),
      .din  (w_wdata),
      .dout (data_out[g*DATA_W +: DATA_W]),
      .full (w_full[g]),
      .empty(w_empty[g])
    );
  end

  assign valid_out = ~w_empty;
  assign busy      = w_busy;
  assign error     = r_error;
  assign drop      = w_drop;

endmodule

// File: tb/tb_router_1xn.sv
// tb/tb_router_1xn.sv - directed self-checking bench for router_1xn (NUM_CH=3, DEPTH=8)
module tb_router_1xn;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        busy;
  logic [2:0]  read_enable;
  logic [2:0]  valid_out;
  logic [23:0] data_out;
  logic        error;
  logic        drop;

  int checks = 0;
  int errors = 0;

  router_1xn #(.NUM_CH(3), .DATA_W(8), .DEPTH(8), .TIMEOUT(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .busy       (busy),
    .read_enable(read_enable),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .error      (error),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, output logic dropped);
    int n;
    n = 0;
    pkt_valid = 1'b1;
    data_in   = b;
    #1;
    while (busy && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: busy=%0b still high after %0d cycles, required 0", busy, n);
    end
    dropped = drop;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic read_byte(input int ch, output logic [7:0] b);
    read_enable[ch] = 1'b1;
    @(posedge clk); #1;
    read_enable[ch] = 1'b0;
    b = data_out[ch*8 +: 8];
  endtask

  task automatic test_reset;
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enable = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL reset_valid_out: got %b, required 000", valid_out); end
    checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data_out: got %h, required 000000", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b, required 0", drop); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_route;
    logic [7:0] exp [5];
    logic [7:0] b;
    logic       d;
    exp = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_byte(exp[0], d);
    checks++; if (valid_out !== 3'b010) begin errors++; $display("FAIL route_hdr_latency: valid_out=%b, required 010", valid_out); end
    for (int i = 1; i < 5; i++) send_byte(exp[i], d);
    @(posedge clk); #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL route_error: got %b, required 0", error); end
    for (int i = 0; i < 5; i++) begin
      read_byte(1, b);
      checks++; if (b !== exp[i]) begin errors++; $display("FAIL route_data[%0d]: got %h, required %h", i, b, exp[i]); end
    end
    checks++; if (valid_out[1] !== 1'b0) begin errors++; $display("FAIL route_empty: valid_out1=%b, required 0", valid_out[1]); end
    read_byte(1, b);
    checks++; if (b !== 8'h0D) begin errors++; $display("FAIL route_read_empty_hold: got %h, required 0d", b); end
  endtask

  task automatic test_parity_error;
    logic [7:0] bad [5];
    logic [7:0] good [3];
    logic [7:0] b;
    logic       d;
    bad  = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    good = '{8'h06, 8'hA5, 8'hA3};
    for (int i = 0; i < 5; i++) send_byte(bad[i], d);
    @(posedge clk); #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL parity_bad_error: got %b, required 1", error); end
    for (int i = 0; i < 5; i++) read_byte(1, b);
    for (int i = 0; i < 3; i++) send_byte(good[i], d);
    checks++; if (valid_out !== 3'b100) begin errors++; $display("FAIL parity_good_dest: valid_out=%b, required 100", valid_out); end
    @(posedge clk); #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL parity_good_clears: got %b, required 0", error); end
    for (int i = 0; i < 3; i++) begin
      read_byte(2, b);
      checks++; if (b !== good[i]) begin errors++; $display("FAIL parity_good_data[%0d]: got %h, required %h", i, b, good[i]); end
    end
  endtask

  task automatic test_drop;
    logic [7:0] bytes [3];
    logic       d;
    int         pulses;
    bytes  = '{8'h07, 8'h5A, 8'h5D};
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], d);
      if (d === 1'b1) pulses++;
      if (i == 2) begin
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL drop_on_last: drop=%b, required 1", d); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL drop_pulse_count: got %0d, required 1", pulses); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_after: got %b, required 0", drop); end
    checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL drop_valid_out: got %b, required 000", valid_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL drop_error: got %b, required 0", error); end
  endtask

  task automatic test_backpressure;
    logic [7:0] pkt [12];
    logic [7:0] b;
    logic       d;
    int         rd;
    pkt[0] = 8'h28;
    pkt[11] = 8'h28;
    for (int i = 1; i <= 10; i++) begin
      pkt[i]  = 8'h40 + 8'(i);
      pkt[11] = pkt[11] ^ pkt[i];
    end
    for (int i = 0; i < 8; i++) send_byte(pkt[i], d);
    pkt_valid = 1'b1; data_in = pkt[8];
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_full: got %b, required 1", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_hold: got %b, required 1", busy); end
    read_byte(0, b);
    rd = 1;
    checks++; if (b !== pkt[0]) begin errors++; $display("FAIL bp_first_read: got %h, required %h", b, pkt[0]); end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after_read: got %b, required 0", busy); end
    @(posedge clk); #1;
    data_in = pkt[9];
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_one_more_only: busy=%b, required 1", busy); end
    for (int k = 9; k < 12; k++) begin
      read_byte(0, b);
      checks++; if (b !== pkt[rd]) begin errors++; $display("FAIL bp_data[%0d]: got %h, required %h", rd, b, pkt[rd]); end
      rd++;
      send_byte(pkt[k], d);
    end
    while (rd < 12) begin
      read_byte(0, b);
      checks++; if (b !== pkt[rd]) begin errors++; $display("FAIL bp_data[%0d]: got %h, required %h", rd, b, pkt[rd]); end
      rd++;
    end
    checks++; if (valid_out[0] !== 1'b0) begin errors++; $display("FAIL bp_drained: valid_out0=%b, required 0", valid_out[0]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL bp_error: got %b, required 0", error); end
  endtask

  task automatic test_reset_midpacket;
    logic [7:0] bad [3];
    logic [7:0] good [5];
    logic [7:0] b;
    logic       d;
    bad  = '{8'h06, 8'hA5, 8'h5C};
    good = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h0C};
    for (int i = 0; i < 3; i++) send_byte(bad[i], d);
    @(posedge clk); #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_error: got %b, required 1", error); end
    send_byte(8'h0D, d);
    send_byte(8'h11, d);
    pkt_valid = 1'b1; data_in = 8'h22; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; pkt_valid = 1'b0;
    #1;
    checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL rst_mid_valid_out: got %b, required 000", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_mid_error: got %b, required 0", error); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_byte(good[i], d);
    @(posedge clk); #1;
    checks++; if (valid_out !== 3'b001) begin errors++; $display("FAIL rst_mid_new_dest: valid_out=%b, required 001", valid_out); end
    for (int i = 0; i < 5; i++) begin
      read_byte(0, b);
      checks++; if (b !== good[i]) begin errors++; $display("FAIL rst_mid_new_data[%0d]: got %h, required %h", i, b, good[i]); end
    end
  endtask

  task automatic test_idle_hold;
    logic [7:0] b;
    logic       d;
    send_byte(8'h06, d);
    send_byte(8'hA5, d);
    send_byte(8'hA3, d);
    repeat (40) @(posedge clk);
    #1;
`ifdef ROUTER_SOFTRST_EN
    checks++; if (valid_out[2] !== 1'b0) begin errors++; $display("FAIL idle_flush: valid_out2=%b, required 0", valid_out[2]); end
`else
    checks++; if (valid_out[2] !== 1'b1) begin errors++; $display("FAIL idle_hold: valid_out2=%b, required 1", valid_out[2]); end
    read_byte(2, b);
    checks++; if (b !== 8'h06) begin errors++; $display("FAIL idle_hold_data: got %h, required 06", b); end
`endif
  endtask

  initial begin
    test_reset();
    test_route();
    test_parity_error();
    test_drop();
    test_backpressure();
    test_reset_midpacket();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
- Parametrised single-input, N-output packet router; next-generation replacement for the fixed 3-channel router top.
- Accepts header/payload/parity packets on one byte-stream input and steers each packet to one of NUM_CH output FIFOs.
- Checks parity and reports errors; drops packets addressed to a non-existent channel.
- Integrates the control FSM, parity register and per-channel FIFOs in one block.

Parameters:
- NUM_CH, 3: number of output channels (2..8).
- DATA_W, 8: byte width of data_in/data_out (>= ADDR_W+2).
- DEPTH, 16: words per output FIFO; power of two, >= 4.
- TIMEOUT, 30: idle-read cycles before channel flush (optional feature only).
- ADDR_W, derived localparam = max(1, $clog2(NUM_CH)): destination field width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  data_in carries a packet byte this cycle.
- data_in  in  DATA_W  packet byte.
- busy  out  1  source must hold data_in/pkt_valid stable; byte not accepted.
- read_enable  in  NUM_CH  per-channel read strobe.
- valid_out  out  NUM_CH  channel FIFO non-empty.
- data_out  out  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
- error  out  1  parity mismatch on last completed packet.
- drop  out  1  one-cycle pulse: invalid-address packet discarded.

Behaviour:
- Packet format: header, then LEN payload bytes, then one parity byte.
  - Header[ADDR_W-1:0] = dest; header[DATA_W-1:ADDR_W] = LEN (0 allowed).
  - Parity = XOR of header and all payload bytes.
  - pkt_valid stays high for every byte; gaps (pkt_valid low) stall the transfer without error.
- Byte accepted iff pkt_valid && !busy.
- Reset values: FSM IDLE, all FIFOs empty, valid_out=0, data_out=0, busy=0, error=0, drop=0, counters 0.
- FSM states:
  - IDLE: on accepted header, latch dest/LEN, set running parity = header. Next state:
    - dest >= NUM_CH -> DROP.
    - dest FIFO has room -> write header into it, go to PAYLOAD (PARITY if LEN=0).
    - dest FIFO full -> WAIT, header held internally.
  - WAIT: busy=1. When dest FIFO not full, write header and go to PAYLOAD/PARITY.
  - PAYLOAD: busy = dest FIFO full (combinational on current full flag).
    - Each accepted byte is written and XORed into parity; LEN counter decrements.
    - After the LENth byte, go to PARITY.
  - PARITY: same busy rule. Accepted byte is written, latched, and compared with running parity; go to CHECK.
  - CHECK: busy=1 for one cycle; error <= mismatch; go to IDLE. error holds until the next CHECK.
  - DROP: busy=0; consume LEN+1 bytes with no FIFO writes. drop=1 on the cycle the final byte is accepted; go to IDLE. error unchanged.
- Header-accept to first possible header-read latency: 2 cycles (write at edge 1, valid_out high after edge 1, data_out registered on read).
- FIFO read: read_enable[i] && valid_out[i] -> data_out slice updates on next edge. Read when empty is ignored and data_out holds.
- Simultaneous read and write on the same FIFO are both performed.
  - Full flag is evaluated before the read, so writes to a full FIFO stall even with a concurrent read.
- Pointers are log2(DEPTH)+1 bits; the wrap bit distinguishes full from empty.
- Reset mid-packet: packet lost, source must restart with a header.

Optional Feature:
- Macro ROUTER_SOFTRST_EN.
- Defined: per-channel counter counts cycles with valid_out[i]=1 and read_enable[i]=0; any read clears it.
  - On reaching TIMEOUT, channel i FIFO is flushed (pointers zeroed, valid_out[i]=0) next cycle.
  - If the FSM is writing channel i at flush, the FSM aborts to IDLE without asserting error.
- Undefined: no counters, no flush; data stays until read.

Decomposition:
- Package router_pkg: FSM state enum (IDLE, WAIT, PAYLOAD, PARITY, CHECK, DROP) and helper function for ADDR_W.
- Sub-module router_fifo (parameters DATA_W, DEPTH; ports clk, reset, flush, we, re, din, dout, full, empty), instantiated NUM_CH times via generate.

Test Plan:
- NUM_CH=3, DATA_W=8: header 8'h0D (dest 1, LEN 3), payload 11,22,33, parity correct; read channel 1 -> data_out1 = 0D,11,22,33,parity; error=0; valid_out1 falls after 5 reads.
- Same packet with parity byte XOR 8'h01 -> error=1 after CHECK; a following good packet clears error=0.
- Header 8'h07 (dest 3, invalid) with LEN 1 -> drop pulses once on 3rd accepted byte; all valid_out stay 0.
- DEPTH=4, dest 0, LEN 6, no reads -> busy rises when the FIFO holds 4 bytes; reading 1 byte lets exactly 1 more byte in; the full packet eventually arrives intact.
- Assert reset during PAYLOAD -> next cycle all valid_out=0, busy=0, error=0; a new packet then routes normally.
- ROUTER_SOFTRST_EN, TIMEOUT=30: fill channel 2, never read -> valid_out2 drops on cycle 31; with the macro undefined it stays high.
